// File: rtl/sram_ctrl.sv
// Controller for a 32-bit word built from two 16-bit asynchronous SRAMs.
// One host access at a time; every SRAM-facing strobe and host output is registered.
module sram_ctrl #(
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [16:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        sram_cs1_n,
  output logic        sram_cs2,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [1:0]  sram_lb_n,
  output logic [1:0]  sram_ub_n,
  output logic [16:0] sram_a,
  output logic [31:0] sram_io_out,
  output logic        sram_io_oe,
  input  logic [31:0] sram_io_in
);

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned CW = 4;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WSETUP = 3'd1;
  localparam logic [2:0] WPULSE = 3'd2;
  localparam logic [2:0] WHOLD  = 3'd3;
  localparam logic [2:0] RPULSE = 3'd4;
  localparam logic [2:0] RDONE  = 3'd5;

  logic [2:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [BW-1:0] be_q, be_d;
  logic [AW-1:0] a_d;
  logic [DW-1:0] io_out_d, rdata_d;
  logic          ready_d, done_d, cs1_n_d, cs2_d, oe_n_d, we_n_d, io_oe_d;
  logic [1:0]    lb_n_d, ub_n_d;

  // Next state and next values of every registered output.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    be_d     = be_q;
    a_d      = sram_a;
    io_out_d = sram_io_out;
    rdata_d  = rdata;
    case (state)
      IDLE: begin
        if (req && ready) begin
          be_d = be;
          a_d  = addr;
          if (we) begin
            io_out_d = wdata;
            // A write with no enabled lanes completes without touching the SRAM.
            state_d  = (be == '0) ? RDONE : WSETUP;
          end else begin
            state_d = RPULSE;
            cnt_d   = CW'(RD_WAIT - 1);
          end
        end
      end
      WSETUP: begin
        state_d = WPULSE;
        cnt_d   = CW'(WR_WAIT - 1);
      end
      WPULSE: begin
        if (cnt == '0) state_d = WHOLD;
        else           cnt_d   = cnt - CW'(1);
      end
      WHOLD: state_d = IDLE;
      RPULSE: begin
        if (cnt == '0) begin
          rdata_d = sram_io_in;
          state_d = RDONE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      RDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = 1'b0;
    done_d  = 1'b0;
    cs1_n_d = 1'b1;
    cs2_d   = 1'b0;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    io_oe_d = 1'b0;
    lb_n_d  = 2'b11;
    ub_n_d  = 2'b11;
    case (state_d)
      IDLE: ready_d = 1'b1;
      WSETUP, WPULSE, WHOLD: begin
        cs1_n_d = 1'b0;
        cs2_d   = 1'b1;
        io_oe_d = 1'b1;
        lb_n_d  = {~be_d[2], ~be_d[0]};
        ub_n_d  = {~be_d[3], ~be_d[1]};
        we_n_d  = (state_d != WPULSE);
        done_d  = (state_d == WHOLD);
      end
      RPULSE: begin
        cs1_n_d = 1'b0;
        cs2_d   = 1'b1;
        oe_n_d  = 1'b0;
        lb_n_d  = 2'b00;
        ub_n_d  = 2'b00;
      end
      RDONE:   done_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      be_q        <= '0;
      ready       <= 1'b0;
      done        <= 1'b0;
      rdata       <= '0;
      sram_cs1_n  <= 1'b1;
      sram_cs2    <= 1'b0;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_lb_n   <= 2'b11;
      sram_ub_n   <= 2'b11;
      sram_a      <= '0;
      sram_io_out <= '0;
      sram_io_oe  <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      be_q        <= be_d;
      ready       <= ready_d;
      done        <= done_d;
      rdata       <= rdata_d;
      sram_cs1_n  <= cs1_n_d;
      sram_cs2    <= cs2_d;
      sram_oe_n   <= oe_n_d;
      sram_we_n   <= we_n_d;
      sram_lb_n   <= lb_n_d;
      sram_ub_n   <= ub_n_d;
      sram_a      <= a_d;
      sram_io_out <= io_out_d;
      sram_io_oe  <= io_oe_d;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: directed vector table, reset abort, and held-req random traffic
// checked against a transaction-level memory model and the bus invariants.
module tb_sram_ctrl;
  localparam int unsigned RD_WAIT = 2;
  localparam int unsigned WR_WAIT = 2;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [16:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready, done;
  logic [31:0] rdata;
  logic        sram_cs1_n, sram_cs2, sram_oe_n, sram_we_n, sram_io_oe;
  logic [1:0]  sram_lb_n, sram_ub_n;
  logic [16:0] sram_a;
  logic [31:0] sram_io_out, sram_io_in;

  sram_ctrl #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready), .done(done), .rdata(rdata),
    .sram_cs1_n(sram_cs1_n), .sram_cs2(sram_cs2), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n), .sram_a(sram_a),
    .sram_io_out(sram_io_out), .sram_io_oe(sram_io_oe), .sram_io_in(sram_io_in)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural SRAM pair: byte-lane writes while we_n is low, data out while oe_n is low.
  logic [31:0] sram_mem [0:63];
  wire chip_on = !sram_cs1_n && sram_cs2;

  always @(posedge clk) begin
    if (chip_on && !sram_we_n && sram_io_oe) begin
      if (!sram_lb_n[0]) sram_mem[sram_a[5:0]][7:0]   <= sram_io_out[7:0];
      if (!sram_ub_n[0]) sram_mem[sram_a[5:0]][15:8]  <= sram_io_out[15:8];
      if (!sram_lb_n[1]) sram_mem[sram_a[5:0]][23:16] <= sram_io_out[23:16];
      if (!sram_ub_n[1]) sram_mem[sram_a[5:0]][31:24] <= sram_io_out[31:24];
    end
  end

  always @(negedge clk)
    sram_io_in = (chip_on && !sram_oe_n) ? sram_mem[sram_a[5:0]] : 32'hDEAD_BEEF;

  // Bus invariants sampled every cycle once out of reset.
  logic        inv_en = 1'b0;
  int          inv_viol = 0;
  logic [16:0] prev_a;
  always @(negedge clk) begin
    if (inv_en) begin
      if (sram_io_oe && !sram_oe_n) inv_viol++;
      if (!sram_we_n && !sram_io_oe) inv_viol++;
      if (!sram_we_n && sram_a != prev_a) inv_viol++;
    end
    prev_a = sram_a;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference memory.
  logic [31:0] ref_mem [0:63];

  int          r_lat, r_we_lo, r_we_first, r_oe_lo, r_oe_first, r_ioe_rd, r_gap;
  logic [31:0] r_rd;
  logic [3:0]  r_lanes;

  // Issue one access from a negedge; req is left high so back-to-back calls stream.
  task automatic access(input logic w, input logic [16:0] a, input logic [31:0] d, input logic [3:0] b);
    r_gap = 0;
    while (!ready && r_gap < 50) begin
      @(negedge clk);
      r_gap++;
    end
    chk("ready_wait", 64'(ready), 64'd1);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    r_lat = -1; r_we_lo = 0; r_we_first = -1; r_oe_lo = 0; r_oe_first = -1; r_ioe_rd = 0;
    r_rd = '0; r_lanes = 4'hx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!sram_we_n) begin
        if (r_we_lo == 0) begin
          r_we_first = k;
          r_lanes = {sram_ub_n, sram_lb_n};
        end
        r_we_lo++;
      end
      if (!sram_oe_n) begin
        if (r_oe_lo == 0) r_oe_first = k;
        r_oe_lo++;
      end
      if (!w && sram_io_oe) r_ioe_rd++;
      if (done) begin
        r_lat = k;
        r_rd = rdata;
        break;
      end
    end
  endtask

  // Run one access and check it against the reference rules.
  task automatic txn(input logic w, input logic [16:0] a, input logic [31:0] d, input logic [3:0] b,
                     input string tag);
    access(w, a, d, b);
    if (w) begin
      chk({tag, "_wlat"}, 64'(r_lat), (b == 4'd0) ? 64'd1 : 64'(WR_WAIT + 2));
      chk({tag, "_we_cycles"}, 64'(r_we_lo), (b == 4'd0) ? 64'd0 : 64'(WR_WAIT));
      if (b != 4'd0) chk({tag, "_we_first"}, 64'(r_we_first), 64'd2);
      for (int i = 0; i < 4; i++)
        if (b[i]) ref_mem[a[5:0]][8*i +: 8] = d[8*i +: 8];
    end else begin
      chk({tag, "_rlat"}, 64'(r_lat), 64'(RD_WAIT + 1));
      chk({tag, "_oe_cycles"}, 64'(r_oe_lo), 64'(RD_WAIT));
      chk({tag, "_oe_first"}, 64'(r_oe_first), 64'd1);
      chk({tag, "_io_oe_in_read"}, 64'(r_ioe_rd), 64'd0);
      chk({tag, "_rdata"}, 64'(r_rd), 64'(ref_mem[a[5:0]]));
    end
  endtask

  typedef struct {
    logic        w;
    logic [16:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp_rd;
    logic [3:0]  exp_lanes;  // {ub_n, lb_n} during the write pulse
  } vec_t;
  vec_t vecs [8];

  initial begin
    logic [16:0] wa;
    logic        seen_done;
    for (int i = 0; i < 64; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    vecs[0] = '{1'b1, 17'h00002, 32'h12345678, 4'hF,    32'h0,        4'b0000};
    vecs[1] = '{1'b0, 17'h00002, 32'h0,        4'h0,    32'h12345678, 4'b0000};
    vecs[2] = '{1'b1, 17'h00004, 32'hAABBCCDD, 4'b0101, 32'h0,        4'b1100};
    vecs[3] = '{1'b0, 17'h00004, 32'h0,        4'h0,    32'h00BB00DD, 4'b0000};
    vecs[4] = '{1'b1, 17'h00006, 32'h99999999, 4'h0,    32'h0,        4'b0000};
    vecs[5] = '{1'b0, 17'h00006, 32'h0,        4'h0,    32'h00000000, 4'b0000};
    vecs[6] = '{1'b1, 17'h00002, 32'hFF000000, 4'b1000, 32'h0,        4'b0111};
    vecs[7] = '{1'b0, 17'h00002, 32'h0,        4'h0,    32'hFF345678, 4'b0000};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl",
        64'({ready, done, sram_cs1_n, sram_cs2, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_io_oe, sram_a}),
        64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 17'd0}));
    chk("reset_data", {rdata, sram_io_out}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(ready), 64'd1);
    inv_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b, $sformatf("vec%0d", i));
      if (vecs[i].w && vecs[i].b != 4'd0)
        chk($sformatf("vec%0d_lanes", i), 64'(r_lanes), 64'(vecs[i].exp_lanes));
      if (!vecs[i].w)
        chk($sformatf("vec%0d_table_rdata", i), 64'(r_rd), 64'(vecs[i].exp_rd));
    end
    req = 1'b0;
    chk("sram_holds_word", 64'(sram_mem[2]), 64'h00000000_FF345678);

    // Reset in the middle of a write pulse.
    while (!ready) @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 17'h00008; wdata = 32'h55AA55AA; be = 4'hF;
    for (int k = 0; k < 10 && sram_we_n; k++) @(negedge clk);
    chk("abort_reached_wpulse", 64'(sram_we_n), 64'd0);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    chk("abort_strobes", 64'({sram_we_n, sram_oe_n, done}), 64'b110);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 64'(ready), 64'd1);
    seen_done = done;
    repeat (4) begin
      @(negedge clk);
      seen_done |= done;
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);

    // Held req, alternating write/read at random addresses.
    wa = 17'd16;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        wa = 17'(16 + $urandom_range(0, 15));
        txn(1'b1, wa, $urandom, 4'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
      end else begin
        txn(1'b0, ($urandom_range(0, 1) == 0) ? wa : 17'(16 + $urandom_range(0, 15)),
            32'h0, 4'h0, $sformatf("rnd%0d", i));
      end
      if (i > 0) chk($sformatf("rnd%0d_idle_gap", i), 64'(r_gap), 64'd1);
    end
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("bus_invariants", 64'(inv_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter RD_WAIT, default 2: cycles OE_n is held low before read data is sampled (legal range 1..15).
REQ-002 Parameter WR_WAIT, default 2: cycles WE_n is held low per write (legal range 1..15).
REQ-003 clk  in  1  single system clock; all logic is on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req  in  1  host access request; sampled only while ready=1.
REQ-006 we  in  1  1=write, 0=read.
REQ-007 addr  in  17  32-bit word address.
REQ-008 wdata  in  32  write data.
REQ-009 be  in  4  byte enables, be[0]=wdata[7:0] ... be[3]=wdata[31:24].
REQ-010 ready  out  1  controller idle; a request is accepted when req&ready.
REQ-011 done  out  1  one-cycle pulse; access complete.
REQ-012 rdata  out  32  read data; valid when done=1 for a read, held until the next read completes.
REQ-013 sram_cs1_n, sram_cs2  out  1 each  chip selects shared by both chips (active: cs1_n=0, cs2=1).
REQ-014 sram_oe_n, sram_we_n  out  1 each  shared output/write enables, active low.
REQ-015 sram_lb_n, sram_ub_n  out  2 each  byte-lane enables, active low; index 0=lower chip (IO[15:0]), index 1=upper chip (IO[31:16]).
REQ-016 sram_a  out  17  shared address.
REQ-017 sram_io_out  out  32  data to drive onto the SRAM bus.
REQ-018 sram_io_oe  out  1  1=top level drives sram_io_out onto the bus; 0=bus tri-stated.
REQ-019 sram_io_in  in  32  data read from the SRAM bus.

Function
REQ-020 All sram_* outputs, ready, done and rdata are registered.
REQ-021 FSM states: IDLE, WSETUP, WPULSE, WHOLD, RPULSE, RDONE.
REQ-022 IDLE: ready=1, cs1_n=1, cs2=0, oe_n=1, we_n=1, io_oe=0; on req&ready, latch addr/wdata/be/we, deassert ready the next cycle.
REQ-023 Write with be==0: perform no SRAM cycle and pulse done in the cycle after acceptance.
REQ-024 WSETUP (1 cycle): chip selected, sram_a=latched addr, io_oe=1, io_out=latched wdata, lane enables = ~be, we_n=1.
REQ-025 WPULSE: we_n=0 for exactly WR_WAIT cycles; address, data and lanes stable.
REQ-026 WHOLD (1 cycle): we_n=1, data still driven, done=1; then IDLE.
REQ-027 Write latency with WR_WAIT=2: acceptance at cycle 0, done at cycle 4, ready high again at cycle 5.
REQ-028 RPULSE: chip selected, sram_a=latched addr, all four lanes enabled, io_oe=0, oe_n=0 for RD_WAIT cycles; sample sram_io_in into rdata at the end of the last cycle.
REQ-029 RDONE (1 cycle): oe_n=1, done=1, rdata valid; then IDLE (this is the turnaround cycle).
REQ-030 Read latency with RD_WAIT=2: acceptance at cycle 0, done at cycle 3.
REQ-031 Invariants: io_oe=1 and oe_n=0 never occur in the same cycle; we_n=0 only while io_oe=1; we_n is never low in a cycle in which sram_a changes.
REQ-032 req while ready=0 is ignored, with no queuing; a host holding req high gets back-to-back accesses, with exactly one IDLE cycle between them.

Reset
REQ-033 On rst: state=IDLE, ready=0 during reset, ready=1 in the first cycle after it, done=0, rdata=0, cs1_n=1, cs2=0, oe_n=1, we_n=1, lanes=2'b11 each, sram_a=0, io_out=0, io_oe=0.
REQ-034 rst during any state aborts the access in the next cycle: we_n and oe_n go high, and no done is issued for the aborted access.

Verification
REQ-035 Write addr=0x00002, wdata=0x12345678, be=4'hF, WR_WAIT=2 -> we_n low for cycles 2-3, lanes all 0, done at cycle 4, SRAM model holds 0x12345678.
REQ-036 Read addr=0x00002 after REQ-035 -> oe_n low for cycles 1-2, io_oe=0 throughout, done at cycle 3 with rdata=0x12345678.
REQ-037 Write addr=0x00004, wdata=0xAABBCCDD, be=4'b0101 to a location holding 0 -> lb_n=2'b00, ub_n=2'b11, readback=0x00BB00DD.
REQ-038 Write with be=0 -> no we_n pulse, done one cycle after acceptance.
REQ-039 Assert rst during WPULSE -> we_n=1 the next cycle, no done, ready=1 after rst drops.
REQ-040 Hold req high with alternating write/read for 20 accesses at random addresses -> every read returns the last write to that address, and the REQ-031 invariants hold on every cycle.
